// File: rtl/fifo_bank4.sv
// Four-channel 12-bit input FIFO bank feeding the arbiter; one shared registered read port.
// Define FIFO_BANK_ERR_STICKY_EN to make error bits sticky until reset (default: one-cycle pulse).
module fifo_bank4 #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            push,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [3:0]            pop,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  fifo_valid,
  output logic [3:0]            empty,
  output logic [3:0]            full,
  output logic [3:0]            almost_full,
  output logic [3:0]            almost_empty,
  output logic [3:0]            error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [4][DEPTH];
  logic [DATA_WIDTH-1:0] data_in [4];
  logic [PW-1:0]         wptr_q [4];
  logic [PW-1:0]         wptr_d [4];
  logic [PW-1:0]         rptr_q [4];
  logic [PW-1:0]         rptr_d [4];
  logic [CW-1:0]         count_q [4];
  logic [CW-1:0]         count_d [4];
  logic [DATA_WIDTH-1:0] fifo_out_q, fifo_out_d;
  logic                  fifo_valid_q, fifo_valid_d;
  logic [3:0]            error_q, error_d;
  logic [3:0]            pop_sel, pop_ok, push_ok, err_now;

  assign data_in[0] = data_in0;
  assign data_in[1] = data_in1;
  assign data_in[2] = data_in2;
  assign data_in[3] = data_in3;

  // A full channel still accepts a push when the same edge pops it, so count stays at DEPTH.
  always_comb begin
    pop_sel      = pop & (~pop + 4'd1);
    pop_ok       = '0;
    push_ok      = '0;
    err_now      = '0;
    fifo_out_d   = fifo_out_q;
    fifo_valid_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      count_d[i] = count_q[i];
      pop_ok[i]  = pop_sel[i] && (count_q[i] != '0);
      push_ok[i] = push[i] && ((count_q[i] != DEPTH_C) || pop_ok[i]);
      err_now[i] = (pop[i] && !pop_sel[i]) || (pop_sel[i] && !pop_ok[i]) ||
                   (push[i] && !push_ok[i]);
      if (push_ok[i]) wptr_d[i] = wptr_q[i] + PW'(1);
      if (pop_ok[i]) begin
        rptr_d[i]    = rptr_q[i] + PW'(1);
        fifo_out_d   = mem_q[i][rptr_q[i]];
        fifo_valid_d = 1'b1;
      end
      case ({push_ok[i], pop_ok[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
`ifdef FIFO_BANK_ERR_STICKY_EN
    error_d = error_q | err_now;
`else
    error_d = err_now;
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i]) mem_q[i][wptr_q[i]] <= data_in[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      fifo_out_q   <= '0;
      fifo_valid_q <= 1'b0;
      error_q      <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        count_q[i] <= count_d[i];
      end
      fifo_out_q   <= fifo_out_d;
      fifo_valid_q <= fifo_valid_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    empty        = '0;
    full         = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int i = 0; i < 4; i++) begin
      empty[i]        = (count_q[i] == '0);
      full[i]         = (count_q[i] == DEPTH_C);
      almost_full[i]  = (count_q[i] >= AF_C);
      almost_empty[i] = (count_q[i] <= AE_C);
    end
  end

  assign fifo_out   = fifo_out_q;
  assign fifo_valid = fifo_valid_q;
  assign error      = error_q;

endmodule
